// File: rtl/fifo_wr_arbiter_if.sv
// fifo_wr_arbiter_if: requester streams plus FIFO write-side signals shared by
// the arbiter (master) and the requesters/FIFO around it (slave).
interface fifo_wr_arbiter_if #(
    parameter int NREQ   = 4,
    parameter int DWIDTH = 8
);
    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_last;
    logic [NREQ*DWIDTH-1:0] req_data;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ-1:0]        grant;
    logic                   busy;
    logic                   fifo_full;
    logic                   fifo_wren;
    logic [DWIDTH-1:0]      fifo_din;

    modport master (
        input  req_valid, req_last, req_data, fifo_full,
        output req_ready, grant, busy, fifo_wren, fifo_din
    );

    modport slave (
        output req_valid, req_last, req_data, fifo_full,
        input  req_ready, grant, busy, fifo_wren, fifo_din
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: shares one FIFO write port between NREQ requesters.
// Round-robin choice in IDLE, then the owner keeps the port until its req_last
// beat. Define ARB_BURST_LIMIT_EN to also end a grant after MAX_BURST beats.
module fifo_wr_arbiter #(
    parameter int NREQ      = 4,
    parameter int DWIDTH    = 8,
    parameter int MAX_BURST = 8
) (
    input logic               clk,
    input logic               rst,
    fifo_wr_arbiter_if.master bus
);
    localparam int IW = $clog2(NREQ);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t          state;
    logic [NREQ-1:0] cur_grant;
    logic            cur_busy;
    logic [IW-1:0]   owner;
    logic [IW-1:0]   last_winner;
    logic [IW-1:0]   winner;
    logic [IW-1:0]   cand;
    logic            any_req;
    logic            beat;
    logic            pkt_end;

`ifdef ARB_BURST_LIMIT_EN
    localparam int CW = $clog2(MAX_BURST + 1);
    logic [CW-1:0]   beat_count;
    logic            burst_done;
    // the beat being accepted now is the MAX_BURST-th of this grant
    assign burst_done = (beat_count == CW'(MAX_BURST - 1));
`endif

    // Round-robin pick: first valid requester after the previous winner
    always_comb begin
        winner  = last_winner;
        any_req = 1'b0;
        cand    = '0;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            cand = IW'((32'(last_winner) + i) % NREQ);
            if (!any_req && bus.req_valid[cand]) begin
                winner  = cand;
                any_req = 1'b1;
            end
        end
    end

    // Beat acceptance and end-of-grant detection for the current owner
    always_comb begin
        beat    = cur_busy & ~rst & bus.req_valid[owner] & ~bus.fifo_full;
`ifdef ARB_BURST_LIMIT_EN
        pkt_end = beat & (bus.req_last[owner] | burst_done);
`else
        pkt_end = beat & bus.req_last[owner];
`endif
    end

    assign bus.req_ready = (cur_busy && !rst && !bus.fifo_full) ? cur_grant : '0;
    assign bus.fifo_wren = beat;
    assign bus.fifo_din  = cur_busy ? bus.req_data[32'(owner) * DWIDTH +: DWIDTH] : '0;
    assign bus.grant     = cur_grant;
    assign bus.busy      = cur_busy;

    // Arbitration FSM with registered grant/busy and fairness pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cur_grant   <= '0;
            cur_busy    <= 1'b0;
            owner       <= '0;
            last_winner <= IW'(NREQ - 1);
`ifdef ARB_BURST_LIMIT_EN
            beat_count  <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        state       <= GRANT;
                        cur_grant   <= NREQ'(1) << winner;
                        cur_busy    <= 1'b1;
                        owner       <= winner;
                        last_winner <= winner;
`ifdef ARB_BURST_LIMIT_EN
                        beat_count  <= '0;
`endif
                    end
                end
                GRANT: begin
`ifdef ARB_BURST_LIMIT_EN
                    if (beat) begin
                        beat_count <= beat_count + 1'b1;
                    end
`endif
                    if (pkt_end) begin
                        state     <= IDLE;
                        cur_grant <= '0;
                        cur_busy  <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    cur_grant <= '0;
                    cur_busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed steps for fifo_wr_arbiter; expected FIFO write
// data is queued when stimulus is loaded and checked as writes appear.
// With ARB_BURST_LIMIT_EN defined the burst-split sequence is exercised.
module tb_fifo_wr_arbiter;
    localparam int NREQ      = 4;
    localparam int DWIDTH    = 8;
    localparam int MAX_BURST = 8;
    localparam int DEPTH     = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    fifo_wr_arbiter_if #(.NREQ(NREQ), .DWIDTH(DWIDTH)) bus ();

    fifo_wr_arbiter #(
        .NREQ(NREQ),
        .DWIDTH(DWIDTH),
        .MAX_BURST(MAX_BURST)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_cmp = 0;
    int n_err = 0;
    int n_wr  = 0;
    int w0;

    logic [7:0] sb[$];
    logic [7:0] exp_din;

    logic [7:0] src_data [NREQ][DEPTH];
    logic       src_last [NREQ][DEPTH];
    int         src_len  [NREQ];
    int         src_pos  [NREQ];

    logic [NREQ-1:0] hold     = '0;
    logic [NREQ-1:0] hold_nxt = '0;
    logic            rst_nxt  = 1'b1;
    logic            full_nxt = 1'b0;

    // Write monitor: every FIFO write must match the next queued expectation
    always @(negedge clk) begin
        if (bus.fifo_wren === 1'b1) begin
            n_wr++;
            n_cmp++;
            assert (bus.fifo_full === 1'b0) else begin
                n_err++;
                $error("FAIL wr_while_full: observed %0b expected 0", bus.fifo_full);
            end
            n_cmp++;
            assert (sb.size() > 0) else begin
                n_err++;
                $error("FAIL sb_unexpected: observed write %0h expected none", bus.fifo_din);
            end
            if (sb.size() > 0) begin
                exp_din = sb.pop_front();
                n_cmp++;
                assert (bus.fifo_din === exp_din) else begin
                    n_err++;
                    $error("FAIL sb_din: observed %0h expected %0h", bus.fifo_din, exp_din);
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            logic v;
            v = !hold[i] && (src_pos[i] < src_len[i]);
            bus.req_valid[i] = v;
            bus.req_last[i]  = v ? src_last[i][src_pos[i]] : 1'b0;
            bus.req_data[i*DWIDTH +: DWIDTH] = v ? src_data[i][src_pos[i]] : 8'h00;
        end
    endtask

    task automatic apply();
        drive();
        #1;
    endtask

    // one clock: retire accepted beats, apply pending controls, settle
    task automatic tick();
        logic [NREQ-1:0] acc;
        acc = bus.req_valid & bus.req_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (acc[i]) src_pos[i]++;
        end
        rst           = rst_nxt;
        hold          = hold_nxt;
        bus.fifo_full = full_nxt;
        drive();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_src();
        for (int i = 0; i < NREQ; i++) begin
            src_len[i] = 0;
            src_pos[i] = 0;
        end
    endtask

    task automatic load(input int r, input int n, input logic [7:0] base, input bit push);
        for (int k = 0; k < n; k++) begin
            src_data[r][src_len[r]] = base + 8'(k);
            src_last[r][src_len[r]] = (k == n - 1);
            if (push) sb.push_back(base + 8'(k));
            src_len[r]++;
        end
    endtask

    task automatic reset_dut();
        rst_nxt       = 1'b1;
        rst           = 1'b1;
        full_nxt      = 1'b0;
        bus.fifo_full = 1'b0;
        hold_nxt      = '0;
        hold          = '0;
        clear_src();
        apply();
        tick();
        chk("rst_ready", 32'(bus.req_ready), 0);
        chk("rst_wren", 32'(bus.fifo_wren), 0);
        rst_nxt = 1'b0;
        tick();
        chk("rst_grant", 32'(bus.grant), 0);
        chk("rst_busy", 32'(bus.busy), 0);
    endtask

    initial begin
        bus.fifo_full = 1'b0;
        clear_src();
        drive();

        // 1: single 3-beat packet from requester 1
        reset_dut();
        load(1, 3, 8'hA1, 1'b1);
        apply();
        chk("t1_c0_grant", 32'(bus.grant), 0);
        chk("t1_c0_wren", 32'(bus.fifo_wren), 0);
        for (int c = 1; c <= 3; c++) begin
            tick();
            chk("t1_grant", 32'(bus.grant), 32'h2);
            chk("t1_ready", 32'(bus.req_ready), 32'h2);
            chk("t1_wren", 32'(bus.fifo_wren), 1);
        end
        tick();
        chk("t1_c4_grant", 32'(bus.grant), 0);
        chk("t1_c4_busy", 32'(bus.busy), 0);
        chk("t1_drain", 32'(sb.size()), 0);

        // 2: all four requesters, two 1-beat packets each, round-robin order
        reset_dut();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                load(i, 1, 8'(16 * (i + 1) + k), 1'b1);
            end
        end
        apply();
        w0 = n_wr;
        for (int c = 1; c <= 16; c++) begin
            tick();
            if (c % 2 == 1) begin
                chk("t2_grant", 32'(bus.grant), 32'(1) << (((c - 1) / 2) % 4));
                chk("t2_wren", 32'(bus.fifo_wren), 1);
            end else begin
                chk("t2_bubble", 32'(bus.grant), 0);
                chk("t2_wren_bubble", 32'(bus.fifo_wren), 0);
            end
        end
        chk("t2_writes", 32'(n_wr - w0), 8);
        chk("t2_drain", 32'(sb.size()), 0);

        // 3: fifo_full for 5 cycles in the middle of requester 2's packet
        reset_dut();
        load(2, 6, 8'hC0, 1'b1);
        apply();
        tick();
        tick();
        full_nxt = 1'b1;
        for (int c = 3; c <= 7; c++) begin
            tick();
            chk("t3_full_ready", 32'(bus.req_ready), 0);
            chk("t3_full_wren", 32'(bus.fifo_wren), 0);
            chk("t3_full_grant", 32'(bus.grant), 32'h4);
            if (c == 7) full_nxt = 1'b0;
        end
        tick();
        chk("t3_resume_wren", 32'(bus.fifo_wren), 1);
        chk("t3_resume_din", 32'(bus.fifo_din), 32'hC2);
        tick();
        tick();
        tick();
        tick();
        chk("t3_end_grant", 32'(bus.grant), 0);
        chk("t3_drain", 32'(sb.size()), 0);

        // 4: owner 0 stalls 3 cycles while requester 1 waits
        reset_dut();
        load(0, 4, 8'hD0, 1'b1);
        load(1, 1, 8'hE0, 1'b1);
        apply();
        tick();
        chk("t4_c1_grant", 32'(bus.grant), 32'h1);
        hold_nxt = 4'b0001;
        for (int c = 2; c <= 4; c++) begin
            tick();
            chk("t4_hold_grant", 32'(bus.grant), 32'h1);
            chk("t4_hold_wren", 32'(bus.fifo_wren), 0);
            chk("t4_hold_ready1", 32'(bus.req_ready[1]), 0);
            if (c == 4) hold_nxt = '0;
        end
        for (int c = 5; c <= 7; c++) begin
            tick();
            chk("t4_resume_grant", 32'(bus.grant), 32'h1);
        end
        tick();
        chk("t4_c8_grant", 32'(bus.grant), 0);
        tick();
        chk("t4_c9_grant", 32'(bus.grant), 32'h2);
        tick();
        chk("t4_drain", 32'(sb.size()), 0);

        // 5: reset after the second beat of a 4-beat packet
        reset_dut();
        load(2, 4, 8'hF0, 1'b0);
        sb.push_back(8'hF0);
        sb.push_back(8'hF1);
        apply();
        tick();
        tick();
        rst_nxt = 1'b1;
        tick();
        chk("t5_rst_ready", 32'(bus.req_ready), 0);
        chk("t5_rst_wren", 32'(bus.fifo_wren), 0);
        rst_nxt = 1'b0;
        clear_src();
        apply();
        tick();
        chk("t5_grant", 32'(bus.grant), 0);
        chk("t5_busy", 32'(bus.busy), 0);
        chk("t5_wren", 32'(bus.fifo_wren), 0);
        load(0, 1, 8'h30, 1'b1);
        load(3, 1, 8'h33, 1'b1);
        apply();
        tick();
        chk("t5_first_req0", 32'(bus.grant), 32'h1);
        tick();
        tick();
        chk("t5_then_req3", 32'(bus.grant), 32'h8);
        tick();
        chk("t5_drain", 32'(sb.size()), 0);

`ifdef ARB_BURST_LIMIT_EN
        // 6: 20-beat stream from requester 3 split into 8/8/4 grants
        reset_dut();
        load(3, 20, 8'h00, 1'b0);
        for (int k = 0; k < 8; k++) sb.push_back(8'(k));
        sb.push_back(8'h55);
        for (int k = 8; k < 20; k++) sb.push_back(8'(k));
        apply();
        w0 = n_wr;
        for (int c = 1; c <= 25; c++) begin
            tick();
            case (c)
                4, 8, 12, 19, 21, 24: chk("t6_grant3", 32'(bus.grant), 32'h8);
                9, 11, 20, 25:        chk("t6_bubble", 32'(bus.grant), 0);
                10:                   chk("t6_grant1", 32'(bus.grant), 32'h2);
                default: ;
            endcase
            if (c == 3) begin
                load(1, 1, 8'h55, 1'b0);
                apply();
            end
        end
        chk("t6_writes", 32'(n_wr - w0), 21);
        chk("t6_drain", 32'(sb.size()), 0);
`else
        // 6: without the burst limit a 10-beat packet keeps one grant
        reset_dut();
        load(3, 10, 8'h60, 1'b1);
        apply();
        for (int c = 1; c <= 11; c++) begin
            tick();
            chk("t6_grant", 32'(bus.grant), (c <= 10) ? 32'h8 : 32'h0);
        end
        chk("t6_drain", 32'(sb.size()), 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
